// File: rtl/tank_shell.sv
// Single-shell controller for the player tank: spawns on a fire-key press, flies once per frame, then reloads.
// Optional build macro SHELL_RANGE_EN adds a flight-frame range limit (MAX_RANGE).
module tank_shell #(
`ifdef SHELL_RANGE_EN
  parameter logic [7:0] MAX_RANGE       = 8'd64,
`endif
  parameter logic [7:0] FIRE_KEY        = 8'h2C,
  parameter logic [9:0] SHELL_SIZE      = 10'd2,
  parameter logic [9:0] SHELL_STEP      = 10'd4,
  parameter logic [7:0] COOLDOWN_FRAMES = 8'd8,
  parameter logic [9:0] X_MIN           = 10'd1,
  parameter logic [9:0] X_MAX           = 10'd639,
  parameter logic [9:0] Y_MIN           = 10'd1,
  parameter logic [9:0] Y_MAX           = 10'd479
) (
  input  logic       frame_clk,
  input  logic       Reset,
  input  logic [7:0] keycode,
  input  logic [9:0] TankX,
  input  logic [9:0] TankY,
  input  logic [9:0] TankS,
  input  logic [1:0] direction,
  input  logic       hit,
  output logic [9:0] ShellX,
  output logic [9:0] ShellY,
  output logic [9:0] ShellS,
  output logic       shell_active,
  output logic       fired,
  output logic [1:0] state_dbg
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FLIGHT   = 2'd1,
    COOLDOWN = 2'd2
  } state_t;

  localparam logic [1:0] DIR_LEFT  = 2'b00;
  localparam logic [1:0] DIR_RIGHT = 2'b01;
  localparam logic [1:0] DIR_DOWN  = 2'b10;
  localparam logic [1:0] DIR_UP    = 2'b11;

  state_t     state;
  logic [1:0] dir_q;
  logic [7:0] cd_cnt;
  logic       fire_prev;
  logic       fire_evt;

  logic [10:0] off11;
  logic [9:0]  spawn_x;
  logic [9:0]  spawn_y;
  logic        spawn_ok;
  logic        step_oob;
  logic        range_done;
  logic        retire;

`ifdef SHELL_RANGE_EN
  logic [7:0] flight_cnt;
  assign range_done = ({1'b0, flight_cnt} + 9'd1) >= {1'b0, MAX_RANGE};
`else
  assign range_done = 1'b0;
`endif

  assign ShellS    = SHELL_SIZE;
  assign state_dbg = state;
  assign fire_evt  = (keycode == FIRE_KEY) && !fire_prev;
  assign retire    = hit || step_oob || range_done;

  // Legality is checked in 11 bits so neither the bound sum nor the tank-minus-offset can wrap.
  always_comb begin
    off11    = {1'b0, TankS} + {1'b0, SHELL_SIZE};
    spawn_x  = TankX;
    spawn_y  = TankY;
    spawn_ok = 1'b0;
    case (direction)
      DIR_LEFT: begin
        spawn_ok = {1'b0, TankX} >= ({1'b0, X_MIN} + off11);
        spawn_x  = TankX - off11[9:0];
      end
      DIR_RIGHT: begin
        spawn_ok = ({1'b0, TankX} + off11) <= {1'b0, X_MAX};
        spawn_x  = TankX + off11[9:0];
      end
      DIR_DOWN: begin
        spawn_ok = ({1'b0, TankY} + off11) <= {1'b0, Y_MAX};
        spawn_y  = TankY + off11[9:0];
      end
      default: begin
        spawn_ok = {1'b0, TankY} >= ({1'b0, Y_MIN} + off11);
        spawn_y  = TankY - off11[9:0];
      end
    endcase
  end

  always_comb begin
    step_oob = 1'b0;
    case (dir_q)
      DIR_LEFT:  step_oob = {1'b0, ShellX} < ({1'b0, X_MIN} + {1'b0, SHELL_STEP});
      DIR_RIGHT: step_oob = ({1'b0, ShellX} + {1'b0, SHELL_STEP}) > {1'b0, X_MAX};
      DIR_DOWN:  step_oob = ({1'b0, ShellY} + {1'b0, SHELL_STEP}) > {1'b0, Y_MAX};
      default:   step_oob = {1'b0, ShellY} < ({1'b0, Y_MIN} + {1'b0, SHELL_STEP});
    endcase
  end

  always_ff @(posedge frame_clk) begin
    if (Reset) begin
      state        <= IDLE;
      ShellX       <= 10'd0;
      ShellY       <= 10'd0;
      shell_active <= 1'b0;
      fired        <= 1'b0;
      cd_cnt       <= 8'd0;
      dir_q        <= DIR_RIGHT;
      fire_prev    <= 1'b0;
`ifdef SHELL_RANGE_EN
      flight_cnt   <= 8'd0;
`endif
    end else begin
      fire_prev <= (keycode == FIRE_KEY);
      fired     <= 1'b0;
      case (state)
        IDLE: begin
          if (fire_evt && spawn_ok) begin
            state        <= FLIGHT;
            ShellX       <= spawn_x;
            ShellY       <= spawn_y;
            dir_q        <= direction;
            shell_active <= 1'b1;
            fired        <= 1'b1;
`ifdef SHELL_RANGE_EN
            flight_cnt   <= 8'd0;
`endif
          end
        end
        FLIGHT: begin
`ifdef SHELL_RANGE_EN
          flight_cnt <= flight_cnt + 8'd1;
`endif
          if (retire) begin
            // Position is frozen at the last in-bounds point on retirement.
            shell_active <= 1'b0;
            if (COOLDOWN_FRAMES == 8'd0) begin
              state <= IDLE;
            end else begin
              state  <= COOLDOWN;
              cd_cnt <= COOLDOWN_FRAMES;
            end
          end else begin
            case (dir_q)
              DIR_LEFT:  ShellX <= ShellX - SHELL_STEP;
              DIR_RIGHT: ShellX <= ShellX + SHELL_STEP;
              DIR_DOWN:  ShellY <= ShellY + SHELL_STEP;
              default:   ShellY <= ShellY - SHELL_STEP;
            endcase
          end
        end
        COOLDOWN: begin
          if (cd_cnt <= 8'd1) begin
            state <= IDLE;
          end else begin
            cd_cnt <= cd_cnt - 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
